// File: rtl/pcie_rst_seq.sv
// Power-on / PCIe reset sequencer for the CPM5N reset pins (POR, PCR init, PERST#0, PL user reset).
// Optional CDO-wait timeout with ERROR state is enabled by defining RST_SEQ_CDO_TIMEOUT_EN.
module pcie_rst_seq #(
    parameter int unsigned POR_CYCLES         = 500,
    parameter int unsigned PERST_DELAY_CYCLES = 100,
    parameter int unsigned HOT_RST_CYCLES     = 1000,
    parameter int unsigned CDO_TIMEOUT_CYCLES = 1048576
) (
    input  logic       sys_clk,
    input  logic       sys_rst_n,
    input  logic       rp_cdo_done,
    input  logic       ep_cdo_done,
    input  logic       hot_rst_req,
    output logic       por_n,
    output logic       pcr_init_state,
    output logic       perst_n,
    output logic       user_reset,
    output logic       seq_done,
    output logic       cdo_timeout,
    output logic [2:0] seq_state
);

    localparam int unsigned MAX_AB = (POR_CYCLES > PERST_DELAY_CYCLES) ? POR_CYCLES : PERST_DELAY_CYCLES;
    localparam int unsigned MAX_CD = (HOT_RST_CYCLES > CDO_TIMEOUT_CYCLES) ? HOT_RST_CYCLES : CDO_TIMEOUT_CYCLES;
    localparam int unsigned MAX_P  = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
    localparam int unsigned CNT_W  = $clog2(MAX_P) + 1;

    typedef enum logic [2:0] {
        POR_HOLD  = 3'd0,
        WAIT_CDO  = 3'd1,
        PERST_DLY = 3'd2,
        RUN       = 3'd3,
        HOT_RST   = 3'd4,
        ERROR     = 3'd5
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             por_q, por_d, pcr_q;
    logic             perst_q, perst_d, ures_q;
    logic             done_q, done_d;
    logic [1:0]       rp_sync, ep_sync;
    logic             cdo_ok;

    assign cdo_ok  = rp_sync[1] & ep_sync[1];
    // Saturating increment: the counter never wraps back to zero.
    assign cnt_inc = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;

`ifdef RST_SEQ_CDO_TIMEOUT_EN
    logic [CNT_W-1:0] wcnt_q, wcnt_d;
    logic             tmo_q, tmo_d;

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            wcnt_q <= '0;
            tmo_q  <= 1'b0;
        end else begin
            wcnt_q <= wcnt_d;
            tmo_q  <= tmo_d;
        end
    end

    assign cdo_timeout = tmo_q;
`else
    assign cdo_timeout = 1'b0;
`endif

    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rp_sync <= '0;
            ep_sync <= '0;
            state_q <= POR_HOLD;
            cnt_q   <= '0;
            por_q   <= 1'b0;
            pcr_q   <= 1'b1;
            perst_q <= 1'b0;
            ures_q  <= 1'b1;
            done_q  <= 1'b0;
        end else begin
            rp_sync <= {rp_sync[0], rp_cdo_done};
            ep_sync <= {ep_sync[0], ep_cdo_done};
            state_q <= state_d;
            cnt_q   <= cnt_d;
            por_q   <= por_d;
            pcr_q   <= ~por_d;
            perst_q <= perst_d;
            ures_q  <= ~perst_d;
            done_q  <= done_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        por_d   = por_q;
        perst_d = perst_q;
        done_d  = done_q;
`ifdef RST_SEQ_CDO_TIMEOUT_EN
        wcnt_d  = '0;
        tmo_d   = tmo_q;
`endif
        case (state_q)
            POR_HOLD: begin
                if (cnt_q == CNT_W'(POR_CYCLES - 1)) begin
                    por_d   = 1'b1;
                    cnt_d   = '0;
                    state_d = WAIT_CDO;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            WAIT_CDO: begin
                perst_d = 1'b0;
                done_d  = 1'b0;
                if (cdo_ok) begin
                    cnt_d   = '0;
                    state_d = PERST_DLY;
                end
`ifdef RST_SEQ_CDO_TIMEOUT_EN
                else if (wcnt_q == CNT_W'(CDO_TIMEOUT_CYCLES - 1)) begin
                    tmo_d   = 1'b1;
                    state_d = ERROR;
                end else begin
                    wcnt_d = (wcnt_q == '1) ? wcnt_q : wcnt_q + 1'b1;
                end
`endif
            end
            PERST_DLY: begin
                if (!cdo_ok) begin
                    cnt_d   = '0;
                    state_d = WAIT_CDO;
                end else if (cnt_q == CNT_W'(PERST_DELAY_CYCLES - 1)) begin
                    perst_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            RUN: begin
                if (!cdo_ok) begin
                    perst_d = 1'b0;
                    done_d  = 1'b0;
                    state_d = WAIT_CDO;
                end else if (hot_rst_req) begin
                    perst_d = 1'b0;
                    done_d  = 1'b0;
                    cnt_d   = '0;
                    state_d = HOT_RST;
                end
            end
            HOT_RST: begin
                if (!cdo_ok) begin
                    state_d = WAIT_CDO;
                end else if (cnt_q == CNT_W'(HOT_RST_CYCLES - 1)) begin
                    perst_d = 1'b1;
                    done_d  = 1'b1;
                    state_d = RUN;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ERROR: begin
                perst_d = 1'b0;
                done_d  = 1'b0;
            end
            default: begin
                perst_d = 1'b0;
                done_d  = 1'b0;
                state_d = WAIT_CDO;
            end
        endcase
    end

    assign por_n          = por_q;
    assign pcr_init_state = pcr_q;
    assign perst_n        = perst_q;
    assign user_reset     = ures_q;
    assign seq_done       = done_q;
    assign seq_state      = state_q;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Directed self-checking bench for pcie_rst_seq with default timing and CDO_TIMEOUT_CYCLES=64.
module tb_pcie_rst_seq;

    logic       sys_clk = 1'b0;
    logic       sys_rst_n = 1'b0;
    logic       rp_cdo_done = 1'b0;
    logic       ep_cdo_done = 1'b0;
    logic       hot_rst_req = 1'b0;
    logic       por_n, pcr_init_state, perst_n, user_reset, seq_done, cdo_timeout;
    logic [2:0] seq_state;

    int checks = 0;
    int failures = 0;

    pcie_rst_seq #(
        .POR_CYCLES        (500),
        .PERST_DELAY_CYCLES(100),
        .HOT_RST_CYCLES    (1000),
        .CDO_TIMEOUT_CYCLES(64)
    ) dut (
        .sys_clk       (sys_clk),
        .sys_rst_n     (sys_rst_n),
        .rp_cdo_done   (rp_cdo_done),
        .ep_cdo_done   (ep_cdo_done),
        .hot_rst_req   (hot_rst_req),
        .por_n         (por_n),
        .pcr_init_state(pcr_init_state),
        .perst_n       (perst_n),
        .user_reset    (user_reset),
        .seq_done      (seq_done),
        .cdo_timeout   (cdo_timeout),
        .seq_state     (seq_state)
    );

    always #5 sys_clk = ~sys_clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic hold_reset(input logic rp, input logic ep);
        sys_rst_n   = 1'b0;
        rp_cdo_done = rp;
        ep_cdo_done = ep;
        hot_rst_req = 1'b0;
        repeat (3) tick();
        sys_rst_n = 1'b1;
    endtask

    task automatic edges_to_por(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (por_n === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic edges_to_perst(input int bound, output int n);
        n = -1;
        for (int k = 1; k <= bound; k++) begin
            tick();
            if (perst_n === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        logic [8:0] obs;
        hold_reset(1'b1, 1'b1);
        sys_rst_n = 1'b0;
        obs = {por_n, pcr_init_state, perst_n, user_reset, seq_done, cdo_timeout, seq_state};
        checks++;
        if (obs !== 9'b0_1_0_1_0_0_000) begin
            failures++;
            $display("FAIL reset_outputs: got %b want %b", obs, 9'b0_1_0_1_0_0_000);
        end
    endtask

    task automatic test_por_release();
        int n;
        hold_reset(1'b1, 1'b1);
        edges_to_por(2000, n);
        checks++;
        if (n != 500) begin
            failures++;
            $display("FAIL por_rise_edge: got %0d want 500", n);
        end
        edges_to_perst(2000, n);
        checks++;
        if (n != 101) begin
            failures++;
            $display("FAIL perst_after_por: got %0d want 101", n);
        end
        checks++;
        if ({seq_done, user_reset, pcr_init_state, seq_state} !== 6'b1_0_0_011) begin
            failures++;
            $display("FAIL run_outputs: got %b want %b",
                     {seq_done, user_reset, pcr_init_state, seq_state}, 6'b1_0_0_011);
        end
    endtask

    task automatic test_late_cdo();
        int n;
        int pcr_bad;
        hold_reset(1'b0, 1'b0);
        n = -1;
        pcr_bad = 0;
        for (int k = 1; k <= 4000; k++) begin
            if (k == 2000) rp_cdo_done = 1'b1;
            if (k == 3000) ep_cdo_done = 1'b1;
            tick();
            checks++;
            if (pcr_init_state !== ~por_n) begin
                failures++;
                pcr_bad++;
                if (pcr_bad < 4)
                    $display("FAIL pcr_tracks_por: edge %0d pcr=%b por_n=%b", k, pcr_init_state, por_n);
            end
`ifndef RST_SEQ_CDO_TIMEOUT_EN
            if (k == 2500) begin
                checks++;
                if ({cdo_timeout, seq_state} !== 4'b0_001) begin
                    failures++;
                    $display("FAIL no_timeout_default: got %b want 0001", {cdo_timeout, seq_state});
                end
            end
`endif
            if (perst_n === 1'b1) begin
                n = k;
                break;
            end
        end
        checks++;
        if (n != 3102) begin
            failures++;
            $display("FAIL late_cdo_perst_edge: got %0d want 3102", n);
        end
    endtask

    task automatic test_hot_reset();
        int n;
        hot_rst_req = 1'b1;
        tick();
        hot_rst_req = 1'b0;
        checks++;
        if ({perst_n, user_reset, seq_done, seq_state} !== 6'b0_1_0_100) begin
            failures++;
            $display("FAIL hot_rst_entry: got %b want 010100", {perst_n, user_reset, seq_done, seq_state});
        end
        n = -1;
        for (int j = 1; j <= 1500; j++) begin
            hot_rst_req = (j == 500);
            tick();
            if (perst_n === 1'b1) begin
                n = j;
                break;
            end
        end
        hot_rst_req = 1'b0;
        checks++;
        if (n != 1000) begin
            failures++;
            $display("FAIL hot_rst_width: got %0d want 1000", n);
        end
        checks++;
        if ({seq_done, seq_state} !== 4'b1_011) begin
            failures++;
            $display("FAIL hot_rst_return: got %b want 1011", {seq_done, seq_state});
        end
    endtask

    task automatic test_cdo_drop();
        int n;
        ep_cdo_done = 1'b0;
        repeat (3) tick();
        checks++;
        if ({perst_n, seq_done, seq_state} !== 5'b0_0_001) begin
            failures++;
            $display("FAIL drop_in_run: got %b want 00001", {perst_n, seq_done, seq_state});
        end
        ep_cdo_done = 1'b1;
        repeat (3) tick();
        checks++;
        if ({perst_n, seq_state} !== 4'b0_010) begin
            failures++;
            $display("FAIL recover_to_dly: got %b want 0010", {perst_n, seq_state});
        end
        repeat (50) tick();
        ep_cdo_done = 1'b0;
        repeat (3) tick();
        checks++;
        if ({perst_n, seq_state} !== 4'b0_001) begin
            failures++;
            $display("FAIL drop_in_dly: got %b want 0001", {perst_n, seq_state});
        end
        ep_cdo_done = 1'b1;
        repeat (3) tick();
        edges_to_perst(500, n);
        checks++;
        if (n != 100) begin
            failures++;
            $display("FAIL dly_restart: got %0d want 100", n);
        end
    endtask

    task automatic test_mid_reset();
        int n;
        logic [8:0] obs;
        ep_cdo_done = 1'b0;
        repeat (3) tick();
        ep_cdo_done = 1'b1;
        repeat (3) tick();
        repeat (10) tick();
        checks++;
        if (seq_state !== 3'd2) begin
            failures++;
            $display("FAIL pre_reset_state: got %0d want 2", seq_state);
        end
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        obs = {por_n, pcr_init_state, perst_n, user_reset, seq_done, cdo_timeout, seq_state};
        checks++;
        if (obs !== 9'b0_1_0_1_0_0_000) begin
            failures++;
            $display("FAIL mid_reset_outputs: got %b want %b", obs, 9'b0_1_0_1_0_0_000);
        end
        edges_to_por(2000, n);
        checks++;
        if (n != 500) begin
            failures++;
            $display("FAIL mid_reset_por: got %0d want 500", n);
        end
        edges_to_perst(2000, n);
        checks++;
        if (n != 101) begin
            failures++;
            $display("FAIL mid_reset_perst: got %0d want 101", n);
        end
    endtask

`ifdef RST_SEQ_CDO_TIMEOUT_EN
    task automatic test_cdo_timeout();
        int n;
        hold_reset(1'b0, 1'b0);
        edges_to_por(2000, n);
        checks++;
        if (n != 500) begin
            failures++;
            $display("FAIL tmo_por: got %0d want 500", n);
        end
        repeat (63) tick();
        checks++;
        if ({cdo_timeout, seq_state} !== 4'b0_001) begin
            failures++;
            $display("FAIL tmo_before: got %b want 0001", {cdo_timeout, seq_state});
        end
        tick();
        checks++;
        if ({cdo_timeout, seq_state} !== 4'b1_101) begin
            failures++;
            $display("FAIL tmo_fire: got %b want 1101", {cdo_timeout, seq_state});
        end
        rp_cdo_done = 1'b1;
        ep_cdo_done = 1'b1;
        repeat (10) tick();
        checks++;
        if ({cdo_timeout, por_n, perst_n, seq_done, seq_state} !== 7'b1_1_0_0_101) begin
            failures++;
            $display("FAIL tmo_sticky: got %b want 1100101",
                     {cdo_timeout, por_n, perst_n, seq_done, seq_state});
        end
        sys_rst_n = 1'b0;
        tick();
        sys_rst_n = 1'b1;
        checks++;
        if ({cdo_timeout, seq_state} !== 4'b0_000) begin
            failures++;
            $display("FAIL tmo_clear: got %b want 0000", {cdo_timeout, seq_state});
        end
    endtask
`endif

    initial begin
        test_reset();
`ifdef RST_SEQ_CDO_TIMEOUT_EN
        test_cdo_timeout();
`else
        test_por_release();
        test_late_cdo();
        test_hot_reset();
        test_cdo_drop();
        test_mid_reset();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
